// File: rtl/enc_symbol_serializer_pkg.sv
// Shared constants and types for the convolutional-encoder symbol path.
// The encoder-side packer imports this same package so both ends agree on symbol order.
package enc_symbol_serializer_pkg;

  localparam int SYM_W         = 2;
  localparam int SYMS_PER_WORD = 8;
  localparam int WORD_W        = SYM_W * SYMS_PER_WORD;
  localparam int BUF_DEPTH     = 2;
  localparam int IDX_W         = $clog2(SYMS_PER_WORD);
  localparam int CNT_W         = $clog2(BUF_DEPTH + 1);

  typedef logic [SYM_W-1:0]  sym_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } shift_state_e;

endpackage

// File: rtl/enc_symbol_serializer_fifo.sv
// Small word FIFO with occupancy count; async active-low reset, sync flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module enc_word_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 16,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  // Flush wins over both ports; over/underflow requests are ignored.
  assign do_push = push_i && !flush_i && (count_q != CW'(DEPTH));
  assign do_pop  = pop_i  && !flush_i && (count_q != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/enc_symbol_serializer.sv
// Unpacks 16-bit packed code words into one 2-bit symbol per clock, symbol 0 = word[1:0] first.
// A 2-entry input buffer lets the next word load on the same edge as symbol 7, so streams are gap-free.
module enc_symbol_serializer
  import enc_symbol_serializer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [WORD_W-1:0]  word_in,
  input  logic               word_valid,
  output logic               word_ready,
  output logic [SYM_W-1:0]   sym_out,
  output logic               sym_valid,
  output logic               sym_first,
  output logic [IDX_W-1:0]   sym_idx,
  output logic               starve,
  output shift_state_e       dbg_state_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYMS_PER_WORD - 1);

  shift_state_e     state_q, state_d;
  word_t            shreg_q, shreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             first_q, first_d;
  logic             starve_q, starve_d;

  word_t            fifo_dout;
  logic [CNT_W-1:0] fifo_cnt;
  logic             push, pop;

  // Handshake: a word transfers on a rising edge where word_valid && word_ready.
  // word_ready depends only on the registered count, flush and rst, never on the pop side,
  // so a full buffer keeps ready low even in a cycle that pops.
  assign word_ready = (fifo_cnt != CNT_W'(BUF_DEPTH)) && !flush && rst;
  assign push       = word_valid && word_ready;

  enc_word_fifo #(
    .DEPTH (BUF_DEPTH),
    .W     (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (word_in),
    .dout_o  (fifo_dout),
    .count_o (fifo_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      first_q  <= 1'b0;
      starve_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      first_q  <= first_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    first_d  = 1'b0;
    starve_d = 1'b0;
    pop      = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      shreg_d = '0;
      idx_d   = '0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (fifo_cnt != '0) begin
            pop     = 1'b1;
            state_d = ST_SHIFT;
            shreg_d = fifo_dout;
            idx_d   = '0;
            valid_d = 1'b1;
            first_d = 1'b1;
          end
        end
        ST_SHIFT: begin
          if (idx_q != LAST_IDX) begin
            idx_d   = idx_q + 1'b1;
            shreg_d = shreg_q >> SYM_W;
          end else if (fifo_cnt != '0) begin
            // Reload on the last symbol so the next word follows with no bubble.
            pop     = 1'b1;
            shreg_d = fifo_dout;
            idx_d   = '0;
            first_d = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            shreg_d  = '0;
            idx_d    = '0;
            valid_d  = 1'b0;
            starve_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign sym_out     = shreg_q[SYM_W-1:0];
  assign sym_valid   = valid_q;
  assign sym_first   = first_q;
  assign sym_idx     = idx_q;
  assign starve      = starve_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_enc_symbol_serializer.sv
// Bench for enc_symbol_serializer: queue-based reference model, per-cycle compare,
// packer-style scoreboard for round trips, and literal expectations for directed cases.
module tb_enc_symbol_serializer;
  import enc_symbol_serializer_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic [WORD_W-1:0] word_in = '0;
  logic             word_valid = 1'b0;
  logic             word_ready;
  logic [SYM_W-1:0] sym_out;
  logic             sym_valid;
  logic             sym_first;
  logic [IDX_W-1:0] sym_idx;
  logic             starve;
  shift_state_e     dbg_state_o;

  int n_checks = 0;
  int n_errors = 0;

  enc_symbol_serializer dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .word_in     (word_in),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .sym_out     (sym_out),
    .sym_valid   (sym_valid),
    .sym_first   (sym_first),
    .sym_idx     (sym_idx),
    .starve      (starve),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Buffer of accepted words, current word, and which symbol of it is on the output.
  word_t mbuf[$];
  logic [WORD_W-1:0] exp_q[$];
  logic  m_active = 1'b0;
  int    m_k = 0;
  word_t m_cur = '0;
  logic  m_starve = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst || flush) begin
      mbuf.delete();
      exp_q.delete();
      m_active = 1'b0;
      m_k      = 0;
      m_cur    = '0;
      m_starve = 1'b0;
    end else begin
      bit acc;
      acc = word_valid && (mbuf.size() != BUF_DEPTH);
      m_starve = 1'b0;
      if (m_active && m_k < SYMS_PER_WORD - 1) begin
        m_k++;
      end else if (mbuf.size() > 0) begin
        m_cur    = mbuf.pop_front();
        m_k      = 0;
        m_active = 1'b1;
      end else if (m_active) begin
        m_active = 1'b0;
        m_k      = 0;
        m_starve = 1'b1;
      end
      if (acc) begin
        mbuf.push_back(word_in);
        exp_q.push_back(word_in);
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    logic [31:0] e_sym;
    e_sym = m_active ? ((32'(m_cur) >> (2 * m_k)) & 32'd3) : 32'd0;
    chk("sym_valid",  32'(sym_valid),  32'(m_active));
    chk("sym_out",    32'(sym_out),    e_sym);
    chk("sym_first",  32'(sym_first),  32'(m_active && m_k == 0));
    chk("sym_idx",    32'(sym_idx),    m_active ? 32'(m_k) : 32'd0);
    chk("starve",     32'(starve),     32'(m_starve));
    chk("word_ready", 32'(word_ready), 32'(rst && !flush && (mbuf.size() != BUF_DEPTH)));
    chk("dbg_state",  32'(dbg_state_o == ST_SHIFT), 32'(m_active));
  end

  // ---------------- scoreboard: packer rebuilds words from the symbol stream ----------------
  logic [WORD_W-1:0] sb_acc = '0;
  int sb_words = 0;

  always @(negedge clk) begin
    if (rst && sym_valid) begin
      if (sym_idx == 0) sb_acc = '0;
      sb_acc = sb_acc | (WORD_W'(sym_out) << (2 * int'(sym_idx)));
      if (sym_idx == IDX_W'(SYMS_PER_WORD - 1)) begin
        if (exp_q.size() == 0) begin
          chk("roundtrip_unexpected", 32'(sb_acc), 32'hFFFF_FFFF);
        end else begin
          chk("roundtrip_word", 32'(sb_acc), 32'(exp_q.pop_front()));
        end
        sb_words++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input word_t w);
    bit acc;
    int t;
    t = 0;
    word_valid = 1'b1;
    word_in    = w;
    do begin
      acc = rst && !flush && (mbuf.size() != BUF_DEPTH);
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 50);
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    word_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [SYM_W-1:0] cap_sym [64];
  logic             cap_first [64];
  logic             cap_valid [64];
  logic             cap_ok;

  task automatic capture(input int n);
    int t;
    t = 0;
    @(negedge clk);
    while (!sym_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    cap_ok = sym_valid;
    for (int i = 0; i < n; i++) begin
      cap_sym[i]   = sym_out;
      cap_first[i] = sym_first;
      cap_valid[i] = sym_valid;
      if (i < n - 1) @(negedge clk);
    end
  endtask

  task automatic wait_idx(input int k);
    int t;
    t = 0;
    @(negedge clk);
    while (!(sym_valid && sym_idx == IDX_W'(k)) && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("wait_idx_reached", 32'(sym_idx), 32'(k));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [SYM_W-1:0] t1_exp [8];
    word_t wn;
    int base;
    t1_exp = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd2};

    #2;
    chk("rst_sym_valid",  32'(sym_valid),  32'd0);
    chk("rst_sym_out",    32'(sym_out),    32'd0);
    chk("rst_word_ready", 32'(word_ready), 32'd0);
    chk("rst_starve",     32'(starve),     32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    idle_cycles(2);

    // Single word 16'hB4E1
    send_word(16'hB4E1);
    word_valid = 1'b0;
    capture(8);
    chk("t1_cap_ok", 32'(cap_ok), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("t1_sym",   32'(cap_sym[i]),   32'(t1_exp[i]));
      chk("t1_first", 32'(cap_first[i]), 32'(i == 0));
    end
    @(negedge clk);
    chk("t1_starve",    32'(starve),    32'd1);
    chk("t1_valid_end", 32'(sym_valid), 32'd0);
    idle_cycles(4);

    // Back-to-back 0000, FFFF, 5555
    fork
      begin
        send_word(16'h0000);
        send_word(16'hFFFF);
        send_word(16'h5555);
        word_valid = 1'b0;
      end
      capture(24);
    join
    chk("t2_cap_ok", 32'(cap_ok), 32'd1);
    for (int i = 0; i < 24; i++) begin
      chk("t2_valid", 32'(cap_valid[i]), 32'd1);
      chk("t2_sym",   32'(cap_sym[i]),   (i < 8) ? 32'd0 : (i < 16) ? 32'd3 : 32'd1);
    end
    @(negedge clk);
    chk("t2_starve", 32'(starve), 32'd1);
    idle_cycles(4);

    // Six words with valid held: ready throttles to one word per 8 cycles
    for (int i = 0; i < 6; i++) send_word(word_t'($urandom));
    idle_cycles(30);
    chk("t3_drained", 32'(exp_q.size()), 32'd0);

    // Random round trip of 256 words with random source gaps
    base = sb_words;
    for (int i = 0; i < 256; i++) begin
      send_word(word_t'($urandom));
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 12));
    end
    idle_cycles(30);
    chk("t4_word_count", 32'(sb_words - base), 32'd256);
    chk("t4_drained",    32'(exp_q.size()),    32'd0);

    // Flush at sym_idx=3 with two words buffered
    send_word(word_t'($urandom));
    send_word(word_t'($urandom));
    send_word(word_t'($urandom));
    word_valid = 1'b0;
    wait_idx(2);
    @(posedge clk);
    #1;
    flush      = 1'b1;
    word_valid = 1'b1;
    word_in    = word_t'($urandom);
    @(negedge clk);
    chk("t5_idx_at_flush",   32'(sym_idx),        32'd3);
    chk("t5_buf_full",       32'(mbuf.size()),    32'd2);
    chk("t5_ready_in_flush", 32'(word_ready),     32'd0);
    @(posedge clk);
    #1;
    flush      = 1'b0;
    word_valid = 1'b0;
    @(negedge clk);
    chk("t5_valid_after", 32'(sym_valid), 32'd0);
    chk("t5_idx_after",   32'(sym_idx),   32'd0);
    idle_cycles(5);
    wn = word_t'($urandom);
    send_word(wn);
    word_valid = 1'b0;
    capture(8);
    chk("t5_cap_ok", 32'(cap_ok), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("t5_sym",   32'(cap_sym[i]),   32'((wn >> (2 * i)) & 16'h3));
      chk("t5_first", 32'(cap_first[i]), 32'(i == 0));
    end
    idle_cycles(4);

    // Async reset at sym_idx=5
    send_word(word_t'($urandom));
    send_word(word_t'($urandom));
    word_valid = 1'b0;
    wait_idx(5);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_sym_valid",  32'(sym_valid),  32'd0);
    chk("t6_sym_out",    32'(sym_out),    32'd0);
    chk("t6_sym_idx",    32'(sym_idx),    32'd0);
    chk("t6_sym_first",  32'(sym_first),  32'd0);
    chk("t6_starve",     32'(starve),     32'd0);
    chk("t6_word_ready", 32'(word_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle_cycles(12);
    wn = word_t'($urandom);
    send_word(wn);
    word_valid = 1'b0;
    capture(8);
    chk("t6_cap_ok", 32'(cap_ok), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("t6_sym", 32'(cap_sym[i]), 32'((wn >> (2 * i)) & 16'h3));
    end
    idle_cycles(4);
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
